// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory access path.
package mem_pkg;

    typedef enum logic [2:0] {
        OpLb  = 3'b000,
        OpLbu = 3'b001,
        OpLh  = 3'b010,
        OpLhu = 3'b011,
        OpLw  = 3'b100,
        OpSb  = 3'b101,
        OpSh  = 3'b110,
        OpSw  = 3'b111
    } mem_op_e;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDone,
        StCancel
    } state_e;

    function automatic logic op_is_store(input logic [2:0] op);
        return op[2] & (op[1] | op[0]);
    endfunction

    function automatic logic [1:0] op_size(input logic [2:0] op);
        logic [1:0] size;
        case (op)
            OpLb, OpLbu, OpSb: size = SizeByte;
            OpLh, OpLhu, OpSh: size = SizeHalf;
            default:           size = SizeWord;
        endcase
        return size;
    endfunction

    function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        logic mis;
        case (op_size(op))
            SizeHalf: mis = addr_lo[0];
            SizeWord: mis = |addr_lo;
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/store_align.sv
// Store lane steering: derives bus size, byte strobes and lane-replicated write data.
module store_align
    import mem_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [1:0]  o_size,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata
);

    always_comb begin
        o_size  = op_size(i_op);
        o_wstrb = 4'b0000;
        o_wdata = '0;
        // Loads leave strobes and data at zero so the bus never sees stale lanes.
        if (op_is_store(i_op)) begin
            case (op_size(i_op))
                SizeByte: begin
                    o_wstrb = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                SizeHalf: begin
                    o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_wdata[15:0]}};
                end
                default: begin
                    o_wstrb = 4'b1111;
                    o_wdata = i_wdata;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: issues one load/store at a time on the
// req/addr_ok/data_ok bus, flags misaligned accesses and hands load words to memdec.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_en,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              flush,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              stall,
    output logic              adel,
    output logic              ades,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic [1:0]        ld_addrch,
    output logic [2:0]        ld_op
);

    state_e r_state;
    state_e w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_op;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [3:0]        r_wstrb;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_misaligned;
    logic              w_err;
    logic              w_can_launch;
    logic              w_launch;
    logic              w_capture;
    logic              w_stall;
    logic              w_req;
    logic              w_ld_valid;
    logic [1:0]        w_size;
    logic [3:0]        w_wstrb;
    logic [DATA_W-1:0] w_wdata;

    store_align u_store_align (
        .i_op      (mem_op),
        .i_addr_lo (mem_addr[1:0]),
        .i_wdata   (mem_wdata),
        .o_size    (w_size),
        .o_wstrb   (w_wstrb),
        .o_wdata   (w_wdata)
    );

    assign w_misaligned = op_misaligned(mem_op, mem_addr[1:0]);
    assign w_err        = mem_en && !flush && w_misaligned;
    assign adel         = w_err && !op_is_store(mem_op);
    assign ades         = w_err && op_is_store(mem_op);

    assign w_can_launch = mem_en && !flush && !w_misaligned;
    assign w_launch     = w_can_launch && ((r_state == StIdle) || (r_state == StDone));

    // A flush racing the response drops the result, so the load word is not captured.
    assign w_capture = (r_state == StWait) && data_data_ok && !flush && !op_is_store(r_op);

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_req        = 1'b0;
        w_ld_valid   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_launch) begin
                    w_state_next = StReq;
                    w_stall      = 1'b1;
                end
            end
            StReq: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                // Once accepted the bus owes a response, so a late flush must drain it.
                if (data_addr_ok) begin
                    w_state_next = flush ? StCancel : StWait;
                end else if (flush) begin
                    w_state_next = StIdle;
                end
            end
            StWait: begin
                w_stall = 1'b1;
                if (data_data_ok) begin
                    w_state_next = flush ? StIdle : StDone;
                end else if (flush) begin
                    w_state_next = StCancel;
                end
            end
            StDone: begin
                w_ld_valid = !op_is_store(r_op);
                if (w_launch) begin
                    w_state_next = StReq;
                    w_stall      = 1'b1;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StCancel: begin
                w_stall = mem_en;
                if (data_data_ok) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr  <= '0;
            r_op    <= '0;
            r_wr    <= 1'b0;
            r_size  <= '0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_launch) begin
                r_addr  <= mem_addr;
                r_op    <= mem_op;
                r_wr    <= op_is_store(mem_op);
                r_size  <= w_size;
                r_wstrb <= w_wstrb;
                r_wdata <= w_wdata;
            end
            if (w_capture) begin
                r_rdata <= data_rdata;
            end
        end
    end

    assign data_req   = w_req;
    assign data_wr    = r_wr;
    assign data_size  = r_size;
    assign data_addr  = r_addr;
    assign data_wstrb = r_wstrb;
    assign data_wdata = r_wdata;
    assign stall      = w_stall;
    assign ld_valid   = w_ld_valid;
    assign ld_rdata   = r_rdata;
    assign ld_addrch  = r_addr[1:0];
    assign ld_op      = r_op;

endmodule
